fx3_slave_fifo_responder: RTL

FX3_SLAVE_FIFO_RESPONDER -- requirements
Module: fx3_slave_fifo_responder

---
 rtl/fx3_slave_fifo_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fx3_slave_fifo_responder.sv
// fx3_slave_fifo_responder: FX3 slave-FIFO socket responder; optional drain pattern checker enabled by FX3_RESP_PATTERN_CHECK_EN.
module fx3_slave_fifo_responder #(
    parameter int DEPTH = 16,
    parameter int PF_WM = 4
) (
    input  logic        clk_pll,
    input  logic        reset_,
    input  logic [1:0]  addr,
    input  logic        slcs,
    input  logic        slwr,
    input  logic        slrd,
    input  logic        sloe,
    input  logic        pkend,
    input  logic [31:0] dq_in,
    output logic [31:0] dq_out,
    output logic        dq_oe,
    output logic        flaga,
    output logic        flagb,
    output logic        flagc,
    output logic        flagd,
    input  logic        refill_en,
    input  logic        drain_en,
    output logic [31:0] rx_word_cnt,
    output logic [15:0] pkt_cnt,
    output logic [15:0] ovf_cnt,
    output logic [15:0] unf_cnt,
    output logic        proto_err,
    output logic [15:0] mis_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] WM_WR = CW'(DEPTH - PF_WM);
    localparam logic [CW-1:0] WM_RD = CW'(PF_WM);

    logic [31:0]   rd_mem [DEPTH];
    logic [31:0]   wr_mem [DEPTH];
    logic [AW-1:0] rd_wp, rd_rp, wr_wp, wr_rp;
    logic [CW-1:0] rd_cnt, wr_cnt, rd_cnt_nxt, wr_cnt_nxt;
    logic [31:0]   gen, p1_data, p2_data;
    logic          p1_vld, p2_vld;
    logic          rd_req, wr_req, bad, rd_push, rd_pop, wr_push, wr_pop;

    assign dq_oe = !slcs && !sloe;

    always_comb begin
        rd_req = !slcs && !slrd && slwr && addr == 2'b11;
        wr_req = !slcs && !slwr && slrd && addr == 2'b00;
        bad = !slcs && ((!slwr && !slrd) || ((!slwr || !slrd) && (addr == 2'b01 || addr == 2'b10)));
        rd_push = refill_en && rd_cnt != FULL;
        rd_pop = rd_req && rd_cnt != '0;
        wr_push = wr_req && wr_cnt != FULL;
        wr_pop = drain_en && wr_cnt != '0;
        rd_cnt_nxt = rd_cnt + CW'(rd_push) - CW'(rd_pop);
        wr_cnt_nxt = wr_cnt + CW'(wr_push) - CW'(wr_pop);
    end

    // Read data passes two pipeline stages so dq_out changes two edges after the strobe.
    always_ff @(posedge clk_pll or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem[i] <= '0;
                wr_mem[i] <= '0;
            end
            rd_wp <= '0;
            rd_rp <= '0;
            wr_wp <= '0;
            wr_rp <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            gen <= '0;
            p1_data <= '0;
            p2_data <= '0;
            p1_vld <= 1'b0;
            p2_vld <= 1'b0;
            dq_out <= '0;
            rx_word_cnt <= '0;
            pkt_cnt <= '0;
            ovf_cnt <= '0;
            unf_cnt <= '0;
            proto_err <= 1'b0;
            flaga <= 1'b1;
            flagb <= 1'b1;
            flagc <= 1'b0;
            flagd <= 1'b0;
        end else begin
            if (rd_push) begin
                rd_mem[rd_wp] <= gen;
                rd_wp <= rd_wp + AW'(1);
                gen <= gen + 32'd1;
            end
            if (rd_pop) begin
                p1_data <= rd_mem[rd_rp];
                rd_rp <= rd_rp + AW'(1);
            end
            p1_vld <= rd_pop;
            p2_vld <= p1_vld;
            p2_data <= p1_data;
            if (p2_vld)
                dq_out <= p2_data;
            if (rd_req && rd_cnt == '0 && unf_cnt != '1)
                unf_cnt <= unf_cnt + 16'd1;
            if (wr_push) begin
                wr_mem[wr_wp] <= dq_in;
                wr_wp <= wr_wp + AW'(1);
                if (!pkend)
                    pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (wr_req && wr_cnt == FULL && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + 16'd1;
            if (wr_pop) begin
                wr_rp <= wr_rp + AW'(1);
                rx_word_cnt <= rx_word_cnt + 32'd1;
            end
            if (bad)
                proto_err <= 1'b1;
            rd_cnt <= rd_cnt_nxt;
            wr_cnt <= wr_cnt_nxt;
            flaga <= wr_cnt_nxt != FULL;
            flagb <= wr_cnt_nxt < WM_WR;
            flagc <= rd_cnt_nxt != '0;
            flagd <= rd_cnt_nxt > WM_RD;
        end
    end

`ifdef FX3_RESP_PATTERN_CHECK_EN
    logic [7:0]  exp_n;
    logic [31:0] rx_word;

    assign rx_word = wr_mem[wr_rp];

    // Bytes are little-endian on the bus; the next expectation always follows the received last byte.
    always_ff @(posedge clk_pll or negedge reset_) begin
        if (!reset_) begin
            exp_n <= '0;
            mis_cnt <= '0;
        end else if (wr_pop) begin
            if (rx_word != {exp_n + 8'd3, exp_n + 8'd2, exp_n + 8'd1, exp_n} && mis_cnt != '1)
                mis_cnt <= mis_cnt + 16'd1;
            exp_n <= rx_word[31:24] + 8'd1;
        end
    end
`else
    logic unused_rx;

    assign unused_rx = ^wr_mem[wr_rp];
    assign mis_cnt = '0;
`endif
endmodule
